mmio_mailbox: RTL

- Memory-mapped responder on the processor data-memory bus. It sits beside DataMemory and uses the same Address / WriteData / ReadData / MemoryRead / MemoryWrite signalling.
- Provides two FIFOs:
  - TX: the CPU writes, the host side drains.
  - RX: the host side fills, the CPU reads.
- Gives the single-cycle core a buffered channel to an external agent, using ordinary load/store instructions.
- Top level selects ReadData from this block over DataMemory whenever Sel is high.

---
 rtl/mmio_mailbox.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_mailbox.sv
// Memory-mapped mailbox: a CPU-to-host TX FIFO and a host-to-CPU RX FIFO behind a
// four-register window on the data-memory bus.
module mmio_mailbox #(
  parameter logic [63:0] BASE  = 64'hFFFF_0000,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 5
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  output logic [63:0] ReadData,
  output logic        Sel,
  output logic [63:0] TxData,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic [63:0] RxData,
  input  logic        RxValid,
  output logic        RxReady
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegRxData = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [1:0] reg_idx;
  logic       bus_wr;
  logic       bus_rd;
  logic       unused_addr;

  assign Sel         = (Address[63:5] == BASE[63:5]);
  assign reg_idx     = Address[4:3];
  assign bus_wr      = Sel && MemoryWrite;
  // A combined read/write applies only the write side.
  assign bus_rd      = Sel && MemoryRead && !MemoryWrite;
  assign unused_addr = ^Address[2:0];

  logic tx_push_req;
  logic ctrl_wr;
  logic rx_pop_req;
  logic tx_flush;
  logic rx_flush;
  logic sticky_clr;

  assign tx_push_req = bus_wr && (reg_idx == RegTxData);
  assign ctrl_wr     = bus_wr && (reg_idx == RegCtrl);
  assign rx_pop_req  = bus_rd && (reg_idx == RegRxData);
  assign tx_flush    = ctrl_wr && WriteData[0];
  assign rx_flush    = ctrl_wr && WriteData[1];
  assign sticky_clr  = ctrl_wr && WriteData[2];

  // ---------------------------------------------------------------------------
  // TX FIFO (CPU pushes, host pops)
  // ---------------------------------------------------------------------------
  logic [63:0]   tx_mem [DEPTH];
  logic [PW-1:0] tx_wptr_q, tx_wptr_d;
  logic [PW-1:0] tx_rptr_q, tx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_full, tx_empty;
  logic          tx_push, tx_pop;
  logic          tx_ovf_q, tx_ovf_d;

  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = tx_push_req && !tx_full;
  assign tx_pop   = TxValid && TxReady;

  assign TxValid = !tx_empty;
  assign TxData  = tx_empty ? 64'h0 : tx_mem[tx_rptr_q];

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // A push into a full FIFO is lost even if the host pops on the same edge.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    if (sticky_clr)                 tx_ovf_d = 1'b0;
    else if (tx_push_req && tx_full) tx_ovf_d = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (tx_push) tx_mem[tx_wptr_q] <= WriteData;
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (host pushes, CPU pops)
  // ---------------------------------------------------------------------------
  logic [63:0]   rx_mem [DEPTH];
  logic [PW-1:0] rx_wptr_q, rx_wptr_d;
  logic [PW-1:0] rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_full, rx_empty;
  logic          rx_push, rx_pop;
  logic          rx_unf_q, rx_unf_d;
  logic [63:0]   rx_head;

  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign RxReady  = !rx_full;
  assign rx_push  = RxValid && RxReady;
  assign rx_pop   = rx_pop_req && !rx_empty;
  assign rx_head  = rx_empty ? 64'h0 : rx_mem[rx_rptr_q];

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_comb begin
    rx_unf_d = rx_unf_q;
    if (sticky_clr)                   rx_unf_d = 1'b0;
    else if (rx_pop_req && rx_empty)  rx_unf_d = 1'b1;
  end

  // Writing during a flush is harmless: the pointers are reset on the same edge.
  always_ff @(posedge Clock) begin
    if (rx_push) rx_mem[rx_wptr_q] <= RxData;
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      rx_unf_q  <= 1'b0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_unf_q  <= rx_unf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [63:0] status;

  always_comb begin
    status        = 64'h0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[4]     = tx_ovf_q;
    status[5]     = rx_unf_q;
    status[15:8]  = 8'(tx_cnt_q);
    status[23:16] = 8'(rx_cnt_q);
  end

  always_comb begin
    ReadData = 64'h0;
    if (Sel && MemoryRead) begin
      unique case (reg_idx)
        RegRxData: ReadData = rx_head;
        RegStatus: ReadData = status;
        default:   ReadData = 64'h0;
      endcase
    end
  end

endmodule
